ms_read_slave: RTL

- Read-direction responder on the master/slave bus.
- Master issues pipelined read requests (address plus request strobe); the block returns register contents on a read-data channel with valid/ready flow control.
- Holds a local 2**ADDR_W x DATA_W register file. Core logic loads it through a local write port.
- Sits alongside the existing write-direction slave so that a master can read back what the core holds.

---
 rtl/ms_pkg.sv | 10 +
 rtl/ms_rsp_fifo.sv | 57 +++++
 rtl/ms_read_slave.sv | 81 ++++++++
 3 files changed

// File: rtl/ms_pkg.sv
// Shared master/slave bus package: default widths and common bus typedefs.
package ms_pkg;

  localparam int MS_ADDR_W = 2;
  localparam int MS_DATA_W = 8;

  typedef logic [MS_ADDR_W-1:0] addr_t;
  typedef logic [MS_DATA_W-1:0] data_t;

endpackage : ms_pkg

// File: rtl/ms_rsp_fifo.sv
// Synchronous response FIFO; push is ignored when full, pop is ignored when empty.
module ms_rsp_fifo
  import ms_pkg::*;
#(
  parameter int DATA_W = MS_DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          din,
  output logic [DATA_W-1:0]          dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wptr_q, rptr_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              do_push, do_pop;

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = cnt_q;
  assign dout    = mem_q[rptr_q];

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop)      cnt_d = cnt_q + CNT_W'(1);
    else if (do_pop && !do_push) cnt_d = cnt_q - CNT_W'(1);
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (do_push) wptr_q <= wptr_q + PTR_W'(1);
      if (do_pop)  rptr_q <= rptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din;
  end

endmodule : ms_rsp_fifo

// File: rtl/ms_read_slave.sv
// Read-direction bus slave: local register file, pipelined read requests, FIFO'd responses.
// Optional MS_READ_STATS_EN adds a saturating 16-bit accepted-request counter (rd_count).
module ms_read_slave
  import ms_pkg::*;
#(
  parameter int ADDR_W = MS_ADDR_W,
  parameter int DATA_W = MS_DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [ADDR_W-1:0] addr,
  input  logic              req,
  output logic              sready,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  input  logic              rready,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
`ifdef MS_READ_STATS_EN
  ,
  output logic [15:0]       rd_count
`endif
);

  localparam int NREG  = 2**ADDR_W;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] regfile_q [NREG];
  logic [DATA_W-1:0] fifo_dout;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full, fifo_empty;
  logic              accept, consume;

  // Readiness comes from the registered count only, so a same-cycle pop never frees a slot.
  assign sready  = (fifo_count < CNT_W'(DEPTH));
  assign accept  = req && !fifo_full;
  assign rvalid  = !fifo_empty;
  assign consume = rvalid && rready;
  assign rdata   = fifo_empty ? '0 : fifo_dout;

  // The push samples regfile_q before this edge's local write lands, giving old-value reads.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < NREG; i++) regfile_q[i] <= '0;
    end else if (wr_en) begin
      regfile_q[wr_addr] <= wr_data;
    end
  end

  ms_rsp_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (accept),
    .pop   (consume),
    .din   (regfile_q[addr]),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef MS_READ_STATS_EN
  logic [15:0] rd_count_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_count_q <= '0;
    end else if (accept && (rd_count_q != 16'hFFFF)) begin
      rd_count_q <= rd_count_q + 16'd1;
    end
  end

  assign rd_count = rd_count_q;
`endif

endmodule : ms_read_slave
